icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped instruction cache between the pipeline fetch stage (datapath side) and the memory controller (cache-control side).
- Builds on the shared cache field types:
  - 26-bit tag, 4-bit index, 2-bit byte offset.
  - 16 frames; each frame holds valid, tag and a one-word block.
- Serves hits combinationally. On a miss, a two-state FSM fetches the word from memory, fills the frame, then serves the hit.

Parameters:
- WORD_W, 32, instruction/address word width.
- IIX_W, 4, index width; frame count = 2**IIX_W.
- BOF_W, 2, byte-offset width.
- TAG_W, 26, tag width; must equal WORD_W-IIX_W-BOF_W.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath fetch address (PC); byte offset ignored.
- ihit  out  1  requested word is valid on imemload this cycle.
- imemload  out  32  instruction word returned to datapath.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  word-aligned address to memory controller.
- iwait  in  1  memory controller busy; low = iload valid this cycle.
- iload  in  32  word returned by memory controller.
- hitcnt  out  32  saturating count of served hits.
- misscnt  out  32  saturating count of misses (fills started).

Behaviour:
- Address split: tag=imemaddr[31:6], idx=imemaddr[5:2], bof=imemaddr[1:0].
- Storage: 16 frames of {valid, tag[25:0], block[31:0]}; only valid is reset.
- Reset (nRST low, asynchronous):
  - all valid bits = 0, state = IDLE;
  - iREN = 0, iaddr = 0, ihit = 0;
  - hitcnt = misscnt = 0, latched miss address = 0.
- Hit (combinational): ihit = imemREN & (state==IDLE) & valid[idx] & (tag[idx]==tag). imemload = block[idx] whenever ihit, else 0.
- FSM IDLE:
  - iREN = 0.
  - If imemREN and not hit: latch imemaddr into missaddr, increment misscnt, go to FETCH next edge.
  - If imemREN low: stay in IDLE, no memory traffic.
- FSM FETCH:
  - iREN = 1, iaddr = {missaddr[31:2], 2'b00}, ihit = 0.
  - While iwait = 1: hold state.
  - When iwait = 0: on that edge write frame[missaddr idx] = {1, missaddr tag, iload}, go to IDLE.
- Miss latency: fill-edge + 1 cycle. The hit is served in the first IDLE cycle after the fill; the fill cycle itself never asserts ihit.
- Address change during FETCH (branch redirect): the fill of the latched missaddr completes regardless. On return to IDLE, the current imemaddr is re-evaluated (may miss again).
- imemREN dropping during FETCH: fill still completes; no abort.
- Conflict: a fill overwrites a valid frame with a different tag unconditionally (no write-back; icache is read-only).
- Counters:
  - hitcnt increments on each cycle with ihit = 1.
  - misscnt increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFFFFFF.
- Reset mid-FETCH: returns to IDLE with all frames invalid. No partial fill is written. iREN drops immediately (asynchronously).
- No self-modifying-code coherence; software guarantees this.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x00000040, memory returns 0x8C010004 after 3 iwait cycles -> iREN=1 with iaddr=0x40 for 4 cycles; frame 0 filled; ihit=1, imemload=0x8C010004 on the next cycle; misscnt=1, hitcnt=1.
- Re-fetch hit: repeat 0x40 then 0x42 -> ihit=1 same cycle for both, no iREN, imemload=0x8C010004, hitcnt +2.
- Conflict eviction: after 0x40 filled, fetch 0x00000080 (same idx 0, tag 2) -> miss, fill with 0x20020005; refetch 0x40 -> misses again; misscnt=3.
- Redirect during FETCH: miss on 0x100, change imemaddr to 0x204 while iwait=1 -> iaddr stays 0x100 until fill; then IDLE misses 0x204 and iaddr=0x204.
- imemREN low: imemREN=0 with invalid cache for 10 cycles -> iREN=0 throughout, counters unchanged, ihit=0.
- Reset mid-FETCH: assert nRST low while iREN=1 -> iREN=0 immediately; after release, fetch the same address -> miss (frame not filled).

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache. Hits are served combinationally;
// a miss parks the FSM in FETCH until the memory controller returns the word.
module icache #(
  parameter int WORD_W = 32,
  parameter int IIX_W  = 4,
  parameter int BOF_W  = 2,
  parameter int TAG_W  = 26
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [31:0]       hitcnt,
  output logic [31:0]       misscnt
);

  localparam int FRAMES = 2 ** IIX_W;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]        state_reg, state_next;
  logic [WORD_W-1:0] missaddr_reg;
  logic [FRAMES-1:0] valid_reg;
  logic [TAG_W-1:0]  tag_mem   [FRAMES];
  logic [WORD_W-1:0] block_mem [FRAMES];
  logic [31:0]       hitcnt_reg, misscnt_reg;

  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic [IIX_W-1:0]  req_idx, fill_idx;
  logic [FRAMES-1:0] frame_hit;
  logic              lookup_hit, start_miss, fill;
  logic              unused_bof;

  assign req_tag    = imemaddr[WORD_W-1 -: TAG_W];
  assign req_idx    = imemaddr[BOF_W +: IIX_W];
  assign fill_tag   = missaddr_reg[WORD_W-1 -: TAG_W];
  assign fill_idx   = missaddr_reg[BOF_W +: IIX_W];
  assign unused_bof = ^{imemaddr[BOF_W-1:0], missaddr_reg[BOF_W-1:0]};

  // One-hot lookup: at most the addressed frame can report a match.
  for (genvar gi = 0; gi < FRAMES; gi++) begin : g_frame
    assign frame_hit[gi] = valid_reg[gi] && (req_idx == IIX_W'(gi)) &&
                           (tag_mem[gi] == req_tag);
  end

  assign lookup_hit = |frame_hit;
  assign ihit       = imemREN && (state_reg == IDLE) && lookup_hit;
  assign imemload   = ihit ? block_mem[req_idx] : '0;
  assign start_miss = imemREN && (state_reg == IDLE) && !lookup_hit;
  assign fill       = (state_reg == FETCH) && !iwait;

  // iREN follows state directly so an asynchronous reset drops it at once.
  assign iREN  = (state_reg == FETCH);
  assign iaddr = iREN ? {missaddr_reg[WORD_W-1:BOF_W], {BOF_W{1'b0}}} : '0;

  assign hitcnt  = hitcnt_reg;
  assign misscnt = misscnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_miss) state_next = FETCH;
      FETCH:   if (!iwait)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      missaddr_reg <= '0;
      valid_reg    <= '0;
      hitcnt_reg   <= '0;
      misscnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start_miss) missaddr_reg <= imemaddr;
      if (fill) valid_reg[fill_idx] <= 1'b1;
      if (ihit && (hitcnt_reg != 32'hFFFF_FFFF)) hitcnt_reg <= hitcnt_reg + 32'd1;
      if (start_miss && (misscnt_reg != 32'hFFFF_FFFF)) misscnt_reg <= misscnt_reg + 32'd1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[fill_idx]   <= fill_tag;
      block_mem[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: hand-tabulated test-plan vectors, corner-case
// sequences, then randomized traffic against a behavioural cache model.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic [31:0] hitcnt, misscnt;

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hitcnt(hitcnt), .misscnt(misscnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] hc;
    logic [31:0] mc;
  } outs_t;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    outs_t       exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: cache contents per index, at most one outstanding miss.
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] pend [$];
  logic [31:0] m_hits, m_misses;
  logic        cur_ren;
  logic [31:0] cur_addr;
  logic        cur_wt;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (w == 32'h40) return 32'h8C01_0004;
    if (w == 32'h80) return 32'h2002_0005;
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic outs_t mk(input logic h, input logic [31:0] ld, input logic r,
                               input logic [31:0] ia, input logic [31:0] hc,
                               input logic [31:0] mc);
    outs_t o;
    o.ihit = h; o.load = ld; o.iren = r; o.iaddr = ia; o.hc = hc; o.mc = mc;
    return o;
  endfunction

  function automatic vec_t v(input logic ren, input logic [31:0] addr, input logic wt,
                             input outs_t e);
    vec_t x;
    x.ren = ren; x.addr = addr; x.wt = wt; x.exp = e;
    return x;
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
  endfunction

  function automatic outs_t model_expect();
    logic h;
    if (pend.size() != 0) return mk(0, 0, 1, pend[0] & ~32'd3, m_hits, m_misses);
    h = cur_ren && model_hit(cur_addr);
    return mk(h, h ? m_data[cur_addr[5:2]] : 32'd0, 0, 0, m_hits, m_misses);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    pend.delete();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_update();
    logic [31:0] a;
    if (pend.size() == 0) begin
      if (cur_ren) begin
        if (model_hit(cur_addr)) begin
          if (m_hits != 32'hFFFF_FFFF) m_hits++;
        end else begin
          pend.push_back(cur_addr);
          if (m_misses != 32'hFFFF_FFFF) m_misses++;
        end
      end
    end else if (!cur_wt) begin
      a = pend.pop_front();
      m_valid[a[5:2]] = 1'b1;
      m_tag[a[5:2]]   = a[31:6];
      m_data[a[5:2]]  = mem_fn(a);
    end
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s %s got=0x%08h want=0x%08h", name, field, got, want);
    end
  endtask

  task automatic check(input string name, input outs_t e);
    cmp(name, "ihit", {31'd0, ihit}, {31'd0, e.ihit});
    cmp(name, "imemload", imemload, e.load);
    cmp(name, "iREN", {31'd0, iREN}, {31'd0, e.iren});
    cmp(name, "iaddr", iaddr, e.iaddr);
    cmp(name, "hitcnt", hitcnt, e.hc);
    cmp(name, "misscnt", misscnt, e.mc);
  endtask

  // Called at posedge+1: apply inputs, let combinational outputs settle.
  task automatic drive(input logic ren, input logic [31:0] addr, input logic wt);
    cur_ren = ren; cur_addr = addr; cur_wt = wt;
    imemREN = ren; imemaddr = addr; iwait = wt;
    iload = (pend.size() != 0) ? mem_fn(pend[0]) : $urandom();
    #1;
  endtask

  task automatic advance();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    imemREN = 1'b0;
    cur_ren = 1'b0;
    model_reset();
    @(posedge CLK);
    #2;
    check("reset", mk(0, 0, 0, 0, 0, 0));
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  vec_t tbl [21];

  initial begin
    tbl[0]  = v(1, 32'h040, 1, mk(0, 0, 0, 0, 0, 0));
    tbl[1]  = v(1, 32'h040, 1, mk(0, 0, 1, 32'h040, 0, 1));
    tbl[2]  = v(1, 32'h040, 1, mk(0, 0, 1, 32'h040, 0, 1));
    tbl[3]  = v(1, 32'h040, 1, mk(0, 0, 1, 32'h040, 0, 1));
    tbl[4]  = v(1, 32'h040, 0, mk(0, 0, 1, 32'h040, 0, 1));
    tbl[5]  = v(1, 32'h040, 1, mk(1, 32'h8C01_0004, 0, 0, 0, 1));
    tbl[6]  = v(1, 32'h042, 1, mk(1, 32'h8C01_0004, 0, 0, 1, 1));
    tbl[7]  = v(1, 32'h040, 1, mk(1, 32'h8C01_0004, 0, 0, 2, 1));
    tbl[8]  = v(1, 32'h080, 1, mk(0, 0, 0, 0, 3, 1));
    tbl[9]  = v(1, 32'h080, 0, mk(0, 0, 1, 32'h080, 3, 2));
    tbl[10] = v(1, 32'h080, 1, mk(1, 32'h2002_0005, 0, 0, 3, 2));
    tbl[11] = v(1, 32'h040, 1, mk(0, 0, 0, 0, 4, 2));
    tbl[12] = v(1, 32'h040, 0, mk(0, 0, 1, 32'h040, 4, 3));
    tbl[13] = v(1, 32'h040, 1, mk(1, 32'h8C01_0004, 0, 0, 4, 3));
    tbl[14] = v(1, 32'h100, 1, mk(0, 0, 0, 0, 5, 3));
    tbl[15] = v(1, 32'h204, 1, mk(0, 0, 1, 32'h100, 5, 4));
    tbl[16] = v(0, 32'h204, 1, mk(0, 0, 1, 32'h100, 5, 4));
    tbl[17] = v(1, 32'h204, 0, mk(0, 0, 1, 32'h100, 5, 4));
    tbl[18] = v(1, 32'h204, 1, mk(0, 0, 0, 0, 5, 4));
    tbl[19] = v(1, 32'h204, 0, mk(0, 0, 1, 32'h204, 5, 5));
    tbl[20] = v(1, 32'h204, 1, mk(1, mem_fn(32'h204), 0, 0, 5, 5));

    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].ren, tbl[i].addr, tbl[i].wt);
      check($sformatf("vec%0d", i), tbl[i].exp);
      advance();
    end

    // imemREN low on a cold cache: no traffic, no counting.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, $urandom_range(0, 255) << 2, 1'($urandom_range(0, 1)));
      check($sformatf("ren_low%0d", i), mk(0, 0, 0, 0, 0, 0));
      advance();
    end

    // Reset in the middle of a fill: iREN must drop before any clock edge.
    do_reset();
    drive(1'b1, 32'h300, 1'b1);
    check("rst_fetch_miss", mk(0, 0, 0, 0, 0, 0));
    advance();
    drive(1'b1, 32'h300, 1'b0);
    check("rst_fetch_busy", mk(0, 0, 1, 32'h300, 0, 1));
    #1;
    nRST = 1'b0;
    #1;
    check("rst_fetch_async", mk(0, 0, 0, 0, 0, 0));
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    drive(1'b1, 32'h300, 1'b0);
    check("rst_refetch_miss", mk(0, 0, 0, 0, 0, 0));
    advance();
    drive(1'b1, 32'h300, 1'b0);
    check("rst_refetch_fill", mk(0, 0, 1, 32'h300, 0, 1));
    advance();
    drive(1'b1, 32'h300, 1'b1);
    check("rst_refetch_hit", mk(1, mem_fn(32'h300), 0, 0, 0, 1));
    advance();

    // Randomized traffic over a small tag pool to force hits and conflicts.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
      drive(($urandom_range(0, 99) < 85), a, 1'($urandom_range(0, 1)));
      check($sformatf("rand%0d", i), model_expect());
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
